// File: rtl/wb_io_bus_ctrl.sv
// Wishbone slave bus controller: decodes each cycle to memory or one of three
// IO devices, drives chip selects and read/write strobes with per-space wait
// states, captures read data from the return mux and returns a one-cycle ack.
module wb_io_bus_ctrl #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2,
  parameter logic [3:0]  IO0_BASE = 4'h0,
  parameter logic [3:0]  IO1_BASE = 4'h1,
  parameter logic [3:0]  IO2_BASE = 4'h2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic        wb_tga_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [15:0] ADR,
  output logic [15:0] DATW,
  input  logic [15:0] MUXDATI,
  output logic        MEMCS_N,
  output logic        IOCS0_N,
  output logic        IOCS1_N,
  output logic        IOCS2_N,
  output logic        RDN,
  output logic        WRN
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        tga_q, tga_d;
  logic [15:0] adr_q, adr_d;
  logic [15:0] datw_q, datw_d;
  logic [15:0] dato_q, dato_d;
  logic        ack_q, ack_d;
  // Active-low selects packed as {IOCS2, IOCS1, IOCS0, MEMCS}
  logic [3:0]  sel_n_q, sel_n_d;
  logic        rdn_q, rdn_d;
  logic        wrn_q, wrn_d;

  // Address decode with IO0 > IO1 > IO2 priority; all ones when unmapped
  function automatic logic [3:0] decode_sel(input logic tga, input logic [3:0] page);
    logic [3:0] sel;
    sel = '1;
    if (!tga)                sel = 4'b1110;
    else if (page == IO0_BASE) sel = 4'b1101;
    else if (page == IO1_BASE) sel = 4'b1011;
    else if (page == IO2_BASE) sel = 4'b0111;
    return sel;
  endfunction

  // State and registered outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      tga_q   <= 1'b0;
      adr_q   <= '0;
      datw_q  <= '0;
      dato_q  <= '0;
      ack_q   <= 1'b0;
      sel_n_q <= '1;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      tga_q   <= tga_d;
      adr_q   <= adr_d;
      datw_q  <= datw_d;
      dato_q  <= dato_d;
      ack_q   <= ack_d;
      sel_n_q <= sel_n_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
    end
  end

  // Next state; outputs are computed for the state being entered so that
  // every device-facing signal comes straight from a flop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    tga_d   = tga_q;
    adr_d   = adr_q;
    datw_d  = datw_q;
    dato_d  = dato_q;
    ack_d   = 1'b0;
    sel_n_d = '1;
    rdn_d   = 1'b1;
    wrn_d   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d   = wb_adr_i;
          datw_d  = wb_dat_i;
          we_d    = wb_we_i;
          tga_d   = wb_tga_i;
          cnt_d   = wb_tga_i ? 4'(IO_WAIT) : 4'(MEM_WAIT);
          sel_n_d = decode_sel(wb_tga_i, wb_adr_i[15:12]);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          sel_n_d = sel_n_q;
          rdn_d   = we_q;
          wrn_d   = !we_q;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          ack_d   = 1'b1;
          state_d = ACK;
          // Unmapped IO read returns zero regardless of the mux
          if (!we_q) dato_d = (&sel_n_q) ? '0 : MUXDATI;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          sel_n_d = sel_n_q;
          rdn_d   = rdn_q;
          wrn_d   = wrn_q;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wb_dat_o = dato_q;
  assign wb_ack_o = ack_q;
  assign ADR      = adr_q;
  assign DATW     = datw_q;
  assign MEMCS_N  = sel_n_q[0];
  assign IOCS0_N  = sel_n_q[1];
  assign IOCS1_N  = sel_n_q[2];
  assign IOCS2_N  = sel_n_q[3];
  assign RDN      = rdn_q;
  assign WRN      = wrn_q;

endmodule

// File: tb/tb_wb_io_bus_ctrl.sv
// Self-checking bench for wb_io_bus_ctrl: table-driven transfers with a
// read-data scoreboard, plus abort, reset and back-to-back sequences.
module tb_wb_io_bus_ctrl;

  logic        clk, rst_n;
  logic        cyc, stb, we, tga;
  logic [15:0] adr, dati, dato, adr_o, datw, mux;
  logic        ack, memcs_n, iocs0_n, iocs1_n, iocs2_n, rdn, wrn;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  wb_io_bus_ctrl #(
    .MEM_WAIT(1),
    .IO_WAIT (2),
    .IO0_BASE(4'h0),
    .IO1_BASE(4'h1),
    .IO2_BASE(4'h2)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_tga_i  (tga),
    .wb_adr_i  (adr),
    .wb_dat_i  (dati),
    .wb_dat_o  (dato),
    .wb_ack_o  (ack),
    .ADR       (adr_o),
    .DATW      (datw),
    .MUXDATI   (mux),
    .MEMCS_N   (memcs_n),
    .IOCS0_N   (iocs0_n),
    .IOCS1_N   (iocs1_n),
    .IOCS2_N   (iocs2_n),
    .RDN       (rdn),
    .WRN       (wrn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack pops one expected read-data value
  always @(negedge clk) begin
    if (rst_n && ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_ack: got ack=1 expected no ack at %0t", $time);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("sb_dat_o", 32'(dato), 32'(e));
      end
    end
  end

  typedef struct {
    string       name;
    logic        tga;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [15:0] mux;
    int          sel;   // 0=MEMCS 1..3=IOCS0..2, -1=none
    int unsigned w;
    logic [15:0] dato;
  } vec_t;

  function automatic logic [3:0] sel_vec();
    return {iocs2_n, iocs1_n, iocs0_n, memcs_n};
  endfunction

  task automatic drive_req(input vec_t v);
    cyc = 1'b1; stb = 1'b1;
    tga = v.tga; we = v.we; adr = v.adr; dati = v.dat; mux = v.mux;
  endtask

  task automatic release_bus();
    cyc = 1'b0; stb = 1'b0;
  endtask

  // One complete transfer, driven at a negedge with the DUT in IDLE
  task automatic run_vec(input vec_t v);
    int unsigned sel_cnt[4];
    int unsigned rd_cnt, wr_cnt, ack_k;
    bit seen_strobe;
    logic [3:0] s;
    sel_cnt = '{0, 0, 0, 0};
    rd_cnt = 0; wr_cnt = 0; ack_k = 0; seen_strobe = 0;
    drive_req(v);
    exp_q.push_back(v.dato);
    for (int unsigned k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      s = sel_vec();
      for (int unsigned i = 0; i < 4; i++) if (!s[i]) sel_cnt[i]++;
      if (!rdn) rd_cnt++;
      if (!wrn) wr_cnt++;
      if (!seen_strobe && (!rdn || !wrn)) begin
        seen_strobe = 1;
        chk({v.name, "_adr"}, 32'(adr_o), 32'(v.adr));
        if (v.we) chk({v.name, "_datw"}, 32'(datw), 32'(v.dat));
      end
      if (ack) begin
        ack_k = k;
        chk({v.name, "_ack_strobes"}, {30'd0, rdn, wrn}, 32'h3);
        chk({v.name, "_ack_sel"}, 32'(s), 32'hF);
        release_bus();
        break;
      end
    end
    chk({v.name, "_latency"}, ack_k, v.w + 3);
    for (int unsigned i = 0; i < 4; i++)
      chk($sformatf("%s_sel%0d_cycles", v.name, i), sel_cnt[i],
          (int'(i) == v.sel) ? v.w + 2 : 0);
    chk({v.name, "_rdn_cycles"}, rd_cnt, v.we ? 0 : v.w + 1);
    chk({v.name, "_wrn_cycles"}, wr_cnt, v.we ? v.w + 1 : 0);
    @(posedge clk); @(negedge clk);
    chk({v.name, "_ack_single"}, 32'(ack), 32'h0);
    chk({v.name, "_dato_hold"}, 32'(dato), 32'(v.dato));
  endtask

  vec_t vecs[7];
  vec_t v;
  logic [15:0] ack_mask;

  initial begin
    vecs[0] = '{"mem_rd",   1'b0, 1'b0, 16'h0040, 16'h0000, 16'hA5A5,  0, 1, 16'hA5A5};
    vecs[1] = '{"io1_wr",   1'b1, 1'b1, 16'h1234, 16'hBEEF, 16'h0000,  2, 2, 16'hA5A5};
    vecs[2] = '{"io_unmap", 1'b1, 1'b0, 16'h7000, 16'h0000, 16'h0000, -1, 2, 16'h0000};
    vecs[3] = '{"io0_rd",   1'b1, 1'b0, 16'h0ABC, 16'h0000, 16'h1357,  1, 2, 16'h1357};
    vecs[4] = '{"io2_rd",   1'b1, 1'b0, 16'h2FFE, 16'h0000, 16'hC0DE,  3, 2, 16'hC0DE};
    vecs[5] = '{"mem_wr",   1'b0, 1'b1, 16'h2000, 16'h5555, 16'h0000,  0, 1, 16'hC0DE};
    vecs[6] = '{"mem_rd2",  1'b0, 1'b0, 16'h1FFF, 16'h0000, 16'hFFFF,  0, 1, 16'hFFFF};

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; tga = 1'b0;
    adr = '0; dati = '0; mux = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_sel", 32'(sel_vec()), 32'hF);
    chk("rst_strobes", {30'd0, rdn, wrn}, 32'h3);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_dato", 32'(dato), 32'h0);
    chk("rst_adr_datw", {adr_o, datw}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Abort an IO read in its second strobe cycle
    v = '{"abort", 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h9999, 1, 2, 16'h0000};
    drive_req(v);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("abort_in_strobe", {30'd0, iocs0_n, rdn}, 32'h0);
    release_bus();
    @(posedge clk); @(negedge clk);
    chk("abort_sel", 32'(sel_vec()), 32'hF);
    chk("abort_strobes", {30'd0, rdn, wrn}, 32'h3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("abort_dato", 32'(dato), 32'hFFFF);
    run_vec('{"post_abort", 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h2468, 1, 2, 16'h2468});

    // Asynchronous reset in the middle of an IO write strobe
    v = '{"rst_mid", 1'b1, 1'b1, 16'h0ABC, 16'h7777, 16'h0000, 1, 2, 16'h0000};
    drive_req(v);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("rst_mid_strobe", {30'd0, iocs0_n, wrn}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_sel", 32'(sel_vec()), 32'hF);
    chk("rst_mid_strobes", {30'd0, rdn, wrn}, 32'h3);
    chk("rst_mid_ack", 32'(ack), 32'h0);
    chk("rst_mid_dato", 32'(dato), 32'h0);
    release_bus();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec('{"post_rst", 1'b0, 1'b1, 16'h0010, 16'h1111, 16'h0000, 0, 1, 16'h0000});

    // Back-to-back: memory read then IO2 write with cyc/stb held high
    v = '{"b2b", 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h4321, 0, 1, 16'h4321};
    drive_req(v);
    exp_q.push_back(16'h4321);
    ack_mask = '0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); @(negedge clk);
      if (ack) ack_mask[k] = 1'b1;
      if (k == 4) begin
        tga = 1'b1; we = 1'b1; adr = 16'h2468; dati = 16'hABCD;
        exp_q.push_back(16'h4321);
      end
      if (k == 5) chk("b2b_idle_gap", {26'd0, sel_vec(), rdn, wrn}, 32'h3F);
      if (k == 6) chk("b2b_setup2", {26'd0, sel_vec(), rdn, wrn}, 32'h1F);
      if (k == 7) chk("b2b_wr_addr_data", {adr_o, datw}, 32'h2468ABCD);
      if (k == 8) chk("b2b_strobe2", {26'd0, sel_vec(), rdn, wrn}, 32'h1E);
      if (k == 10 && ack) release_bus();
    end
    release_bus();
    chk("b2b_ack_positions", 32'(ack_mask), 32'h0410);

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
